// File: rtl/dbg_trace_pkg.sv
// Shared definitions for the PC trace block.
// Contents: FSM state encoding, control-word bit indices, status-word bit positions,
// and a helper that packs the status word.
package dbg_trace_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } trace_state_e;

    // Control word bit indices
    localparam int unsigned CTRL_ARM  = 0;
    localparam int unsigned CTRL_POP  = 1;
    localparam int unsigned CTRL_CLR  = 2;
    localparam int unsigned CTRL_BPEN = 3;

    // Status word bit positions
    localparam int unsigned STAT_COUNT_LSB = 0;
    localparam int unsigned STAT_EMPTY     = 5;
    localparam int unsigned STAT_FULL      = 6;
    localparam int unsigned STAT_OVF       = 7;
    localparam int unsigned STAT_STATE_LSB = 8;
    localparam int unsigned STAT_HALT      = 10;

    function automatic logic [31:0] pack_status(
        input logic [4:0] count,
        input logic       empty,
        input logic       full,
        input logic       ovf,
        input logic [1:0] state,
        input logic       halt
    );
        logic [31:0] s;
        s = '0;
        s[STAT_COUNT_LSB +: 5] = count;
        s[STAT_EMPTY]          = empty;
        s[STAT_FULL]           = full;
        s[STAT_OVF]            = ovf;
        s[STAT_STATE_LSB +: 2] = state;
        s[STAT_HALT]           = halt;
        return s;
    endfunction

endpackage

// File: rtl/dbg_trace_fifo.sv
// Circular trace buffer with overwrite-on-full.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_push, i_data   write an entry (overwrites oldest when full)
//   i_pop            discard the oldest entry (ignored when empty)
//   i_flush          empty the buffer; dominates push/pop
//   o_head           oldest entry (undefined when empty; caller gates it)
//   o_count          number of valid entries (0..DEPTH)
//   o_full, o_empty  occupancy flags
//   o_overwrite      this cycle's push drops the oldest entry
module dbg_trace_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic [AW:0]      o_count,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_overwrite
);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic [AW-1:0]    w_wr_nxt, w_rd_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_full, w_empty, w_pop_ok, w_push_ok;

    assign w_full    = (r_count == CNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_push_ok = i_push & ~i_flush;
    assign w_pop_ok  = i_pop & ~i_flush & ~w_empty;

    // Push and pop compose: a push on a full buffer already advances rd,
    // so a simultaneous pop advances it a second time.
    always_comb begin
        w_wr_nxt  = r_wr_ptr;
        w_rd_nxt  = r_rd_ptr;
        w_cnt_nxt = r_count;
        if (i_flush) begin
            w_wr_nxt  = '0;
            w_rd_nxt  = '0;
            w_cnt_nxt = '0;
        end else begin
            if (i_push) begin
                w_wr_nxt = r_wr_ptr + AW'(1);
                if (w_full) w_rd_nxt = r_rd_ptr + AW'(1);
                else        w_cnt_nxt = r_count + CW'(1);
            end
            if (w_pop_ok) begin
                w_rd_nxt  = w_rd_nxt + AW'(1);
                w_cnt_nxt = w_cnt_nxt - CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_cnt_nxt;
        end
    end

    // Storage needs no reset: reads are gated by o_empty.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head      = r_mem[r_rd_ptr];
    assign o_count     = r_count;
    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_overwrite = w_push_ok & w_full;

endmodule

// File: rtl/dbg_pc_trace.sv
// Retired-PC trace capture with breakpoint trigger and halt request.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   pc_in        PC retiring this cycle, qualified by pc_valid
//   ctrl_in      bit0 arm (level), bit1 pop (toggle), bit2 clear (rising edge), bit3 bp_en
//   bp_addr      breakpoint PC
//   pc_out       oldest buffered PC, 0 when empty (registered)
//   status_out   [4:0] count, [5] empty, [6] full, [7] overflow, [9:8] state, [10] halt
//   halt_req     high while in DONE (registered)
module dbg_pc_trace
    import dbg_trace_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned POST  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    input  logic            pc_valid,
    input  logic [31:0]     ctrl_in,
    input  logic [XLEN-1:0] bp_addr,
    output logic [XLEN-1:0] pc_out,
    output logic [31:0]     status_out,
    output logic            halt_req
);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] POST_LIM = CW'(POST);

    trace_state_e    r_state, w_state_nxt;
    logic [2:0]      r_ctrl_q;
    logic [CW-1:0]   r_post_cnt, w_post_nxt;
    logic            r_ovf, r_halt, w_halt_nxt;
    logic [XLEN-1:0] r_pc_out;
    logic [31:0]     r_status;

    logic            w_arm_rise, w_pop_ev, w_clr_rise, w_bp_hit;
    logic            w_push, w_flush;
    logic [XLEN-1:0] w_head;
    logic [CW-1:0]   w_count;
    logic            w_full, w_empty, w_overwrite;
    logic            w_unused_ctrl;

    assign w_unused_ctrl = ^ctrl_in[31:4];

    assign w_arm_rise = ctrl_in[CTRL_ARM] & ~r_ctrl_q[CTRL_ARM];
    assign w_pop_ev   = ctrl_in[CTRL_POP] ^ r_ctrl_q[CTRL_POP];
    assign w_clr_rise = ctrl_in[CTRL_CLR] & ~r_ctrl_q[CTRL_CLR];
    assign w_bp_hit   = ctrl_in[CTRL_BPEN] & (pc_in == bp_addr);

    always_comb begin
        w_state_nxt = r_state;
        w_post_nxt  = r_post_cnt;
        w_push      = 1'b0;
        w_flush     = 1'b0;
        if (w_clr_rise) begin
            w_flush     = 1'b1;
            w_state_nxt = StIdle;
        end else if (r_state != StIdle && !ctrl_in[CTRL_ARM]) begin
            // Disarm keeps buffer contents for readout.
            w_state_nxt = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_arm_rise) begin
                        w_flush     = 1'b1;
                        w_state_nxt = StArmed;
                    end
                end
                StArmed: begin
                    if (pc_valid) begin
                        w_push = 1'b1;
                        if (w_bp_hit) begin
                            w_post_nxt  = CW'(1);
                            w_state_nxt = (POST_LIM == CW'(1)) ? StDone : StCapture;
                        end
                    end
                end
                StCapture: begin
                    if (pc_valid) begin
                        w_push     = 1'b1;
                        w_post_nxt = r_post_cnt + CW'(1);
                        if (w_post_nxt == POST_LIM) w_state_nxt = StDone;
                    end
                end
                StDone: ;
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    // Halt rises the cycle after DONE is entered and drops on the exit edge.
    assign w_halt_nxt = (r_state == StDone) && (w_state_nxt == StDone);

    dbg_trace_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .i_clk       (clk),
        .i_rst       (reset),
        .i_push      (w_push),
        .i_pop       (w_pop_ev),
        .i_flush     (w_flush),
        .i_data      (pc_in),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_overwrite (w_overwrite)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_ctrl_q   <= '0;
            r_post_cnt <= '0;
            r_ovf      <= 1'b0;
            r_halt     <= 1'b0;
            r_pc_out   <= '0;
            r_status   <= pack_status(5'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        end else begin
            r_state    <= w_state_nxt;
            r_ctrl_q   <= ctrl_in[2:0];
            r_post_cnt <= w_post_nxt;
            r_ovf      <= w_flush ? 1'b0 : (r_ovf | w_overwrite);
            r_halt     <= w_halt_nxt;
            r_pc_out   <= w_empty ? '0 : w_head;
            r_status   <= pack_status(5'(w_count), w_empty, w_full, r_ovf, r_state, w_halt_nxt);
        end
    end

    assign pc_out     = r_pc_out;
    assign status_out = r_status;
    assign halt_req   = r_halt;

endmodule
